// File: rtl/softmax_pkg.sv
// Shared types and helpers for the softmax row-max subtraction stage.
// Saturating difference is selected in the top via SOFTMAX_MAXSUB_SAT_EN.
package softmax_pkg;

   typedef enum logic {
      COLLECT = 1'b0,
      EMIT    = 1'b1
   } state_e;

   function automatic int unsigned elems_f(input int unsigned chunk, input int unsigned cores_a,
                                           input int unsigned cores_b, input int unsigned modules);
      return chunk * cores_a * cores_b * modules;
   endfunction

   function automatic int unsigned lane_bits_f(input int unsigned width, input int unsigned elems);
      return width * elems;
   endfunction

   // Operands are sign-extended to 32 bits by the caller; element widths stay below 32.
   function automatic logic signed [31:0] smax(input logic signed [31:0] a, input logic signed [31:0] b);
      return (a > b) ? a : b;
   endfunction

   // Difference clamped at the most negative w-bit value; caller keeps the low w bits.
   function automatic logic signed [31:0] sat_sub(input logic signed [31:0] x, input logic signed [31:0] m,
                                                  input int unsigned w);
      logic signed [31:0] d;
      logic signed [31:0] lo;
      d  = x - m;
      lo = -(32'sd1 <<< (w - 1));
      return (d < lo) ? lo : d;
   endfunction

endpackage

// File: rtl/vec_max_reduce.sv
// Combinational signed maximum over every element of one multi-lane beat.
module vec_max_reduce
   import softmax_pkg::*;
#(
   parameter int unsigned WIDTH_OUT     = 16,
   parameter int unsigned ELEMS         = 32,
   parameter int unsigned TOTAL_INPUT_W = 2,
   localparam int unsigned LANE_BITS    = WIDTH_OUT * ELEMS
) (
   input  logic [TOTAL_INPUT_W-1:0][LANE_BITS-1:0] i_beat,
   output logic signed [WIDTH_OUT-1:0]             o_max
);

   logic signed [WIDTH_OUT-1:0] w_elem;

   always_comb begin
      o_max  = i_beat[0][LANE_BITS-1 -: WIDTH_OUT];
      w_elem = '0;
      for (int unsigned l = 0; l < TOTAL_INPUT_W; l++) begin
         for (int unsigned e = 0; e < ELEMS; e++) begin
            w_elem = i_beat[l][LANE_BITS - e*WIDTH_OUT - 1 -: WIDTH_OUT];
            o_max  = WIDTH_OUT'(smax(32'(w_elem), 32'(o_max)));
         end
      end
   end

endmodule

// File: rtl/softmax_max_sub.sv
// Buffers one score row, finds its signed maximum, then streams x - max per element.
// Define SOFTMAX_MAXSUB_SAT_EN to saturate differences instead of wrapping them.
module softmax_max_sub
   import softmax_pkg::*;
#(
   parameter int unsigned WIDTH_OUT      = 16,
   parameter int unsigned FRAC_WIDTH_OUT = 8,
   parameter int unsigned CHUNK_SIZE     = 4,
   parameter int unsigned NUM_CORES_A    = 4,
   parameter int unsigned NUM_CORES_B    = 1,
   parameter int unsigned TOTAL_MODULES  = 2,
   parameter int unsigned TOTAL_INPUT_W  = 2,
   parameter int unsigned ROW_BEATS      = 4,
   localparam int unsigned ELEMS     = elems_f(CHUNK_SIZE, NUM_CORES_A, NUM_CORES_B, TOTAL_MODULES),
   localparam int unsigned LANE_BITS = lane_bits_f(WIDTH_OUT, ELEMS)
) (
   input  logic                                    clk,
   input  logic                                    rst_n,
   input  logic [TOTAL_INPUT_W-1:0][LANE_BITS-1:0] in_scores,
   input  logic                                    in_valid,
   output logic                                    in_ready,
   output logic [TOTAL_INPUT_W-1:0][LANE_BITS-1:0] out_norm,
   output logic                                    out_valid,
   input  logic                                    out_ready,
   output logic                                    out_last,
   output logic [WIDTH_OUT-1:0]                    out_row_max
);

   localparam int unsigned     IDX_W    = (ROW_BEATS > 1) ? $clog2(ROW_BEATS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROW_BEATS - 1);

   if (FRAC_WIDTH_OUT > WIDTH_OUT) begin : g_bad_frac
      $error("FRAC_WIDTH_OUT exceeds WIDTH_OUT");
   end

   state_e                                                r_state, w_state_nxt;
   logic [ROW_BEATS-1:0][TOTAL_INPUT_W-1:0][LANE_BITS-1:0] r_buf;
   logic [IDX_W-1:0]                                      r_wr_idx, r_rd_idx;
   logic signed [WIDTH_OUT-1:0]                           r_run_max, r_row_max;
   logic signed [WIDTH_OUT-1:0]                           w_beat_max, w_cand;
   logic [TOTAL_INPUT_W-1:0][LANE_BITS-1:0]               w_rd_beat;
   logic                                                  w_in_fire, w_out_fire;

   vec_max_reduce #(
      .WIDTH_OUT     (WIDTH_OUT),
      .ELEMS         (ELEMS),
      .TOTAL_INPUT_W (TOTAL_INPUT_W)
   ) u_max (
      .i_beat (in_scores),
      .o_max  (w_beat_max)
   );

   assign in_ready    = (r_state == COLLECT);
   assign out_valid   = (r_state == EMIT);
   assign out_last    = (r_state == EMIT) && (r_rd_idx == LAST_IDX);
   assign out_row_max = r_row_max;
   assign w_in_fire   = in_valid && in_ready;
   assign w_out_fire  = out_valid && out_ready;

   // First beat of a row seeds the max so a previous row's value never leaks in.
   assign w_cand = (r_wr_idx == '0) ? w_beat_max
                                    : WIDTH_OUT'(smax(32'(r_run_max), 32'(w_beat_max)));

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         COLLECT: if (w_in_fire && (r_wr_idx == LAST_IDX)) w_state_nxt = EMIT;
         EMIT:    if (w_out_fire && (r_rd_idx == LAST_IDX)) w_state_nxt = COLLECT;
         default: w_state_nxt = COLLECT;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= COLLECT;
         r_buf     <= '0;
         r_wr_idx  <= '0;
         r_rd_idx  <= '0;
         r_run_max <= '0;
         r_row_max <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_in_fire) begin
            r_buf[r_wr_idx] <= in_scores;
            r_run_max       <= w_cand;
            if (r_wr_idx == LAST_IDX) begin
               r_row_max <= w_cand;
               r_wr_idx  <= '0;
            end else begin
               r_wr_idx <= r_wr_idx + IDX_W'(1);
            end
         end
         if (w_out_fire) begin
            r_rd_idx <= (r_rd_idx == LAST_IDX) ? '0 : r_rd_idx + IDX_W'(1);
         end
      end
   end

   assign w_rd_beat = r_buf[r_rd_idx];

   for (genvar l = 0; l < TOTAL_INPUT_W; l++) begin : g_lane
      for (genvar e = 0; e < ELEMS; e++) begin : g_elem
         logic signed [WIDTH_OUT-1:0] w_x;
         assign w_x = w_rd_beat[l][LANE_BITS - e*WIDTH_OUT - 1 -: WIDTH_OUT];
`ifdef SOFTMAX_MAXSUB_SAT_EN
         logic signed [31:0] w_sat;
         assign w_sat = sat_sub(32'(w_x), 32'(r_row_max), WIDTH_OUT);
         assign out_norm[l][LANE_BITS - e*WIDTH_OUT - 1 -: WIDTH_OUT] = w_sat[WIDTH_OUT-1:0];
`else
         logic signed [WIDTH_OUT:0] w_diff;
         assign w_diff = {w_x[WIDTH_OUT-1], w_x} - {r_row_max[WIDTH_OUT-1], r_row_max};
         assign out_norm[l][LANE_BITS - e*WIDTH_OUT - 1 -: WIDTH_OUT] = w_diff[WIDTH_OUT-1:0];
`endif
      end
   end

endmodule

// File: tb/tb_softmax_max_sub.sv
// Directed bench: ROW_BEATS=2 instance for row tests, ROW_BEATS=1 instance for streaming.
module tb_softmax_max_sub;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;

   logic [63:0] a_in_scores, a_out_norm;
   logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_last;
   logic [15:0] a_out_row_max;

   logic [63:0] b_in_scores, b_out_norm;
   logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_last;
   logic [15:0] b_out_row_max;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   softmax_max_sub #(
      .WIDTH_OUT(16), .FRAC_WIDTH_OUT(8), .CHUNK_SIZE(4), .NUM_CORES_A(1),
      .NUM_CORES_B(1), .TOTAL_MODULES(1), .TOTAL_INPUT_W(1), .ROW_BEATS(2)
   ) dut_a (
      .clk(clk), .rst_n(rst_n), .in_scores(a_in_scores), .in_valid(a_in_valid),
      .in_ready(a_in_ready), .out_norm(a_out_norm), .out_valid(a_out_valid),
      .out_ready(a_out_ready), .out_last(a_out_last), .out_row_max(a_out_row_max)
   );

   softmax_max_sub #(
      .WIDTH_OUT(16), .FRAC_WIDTH_OUT(8), .CHUNK_SIZE(4), .NUM_CORES_A(1),
      .NUM_CORES_B(1), .TOTAL_MODULES(1), .TOTAL_INPUT_W(1), .ROW_BEATS(1)
   ) dut_b (
      .clk(clk), .rst_n(rst_n), .in_scores(b_in_scores), .in_valid(b_in_valid),
      .in_ready(b_in_ready), .out_norm(b_out_norm), .out_valid(b_out_valid),
      .out_ready(b_out_ready), .out_last(b_out_last), .out_row_max(b_out_row_max)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic send_row(input logic [63:0] b0, input logic [63:0] b1);
      a_in_valid = 1'b1; a_in_scores = b0;
      @(negedge clk);
      a_in_scores = b1;
      @(negedge clk);
      a_in_valid = 1'b0; a_in_scores = '0;
   endtask

   // Entered at the first negedge of EMIT with a_out_ready = 1.
   task automatic check_emit(input string tag, input logic [63:0] e0, input logic [63:0] e1,
                             input logic [15:0] emax);
      check({tag, "_valid"},  64'(a_out_valid), 64'(1));
      check({tag, "_inrdy0"}, 64'(a_in_ready), 64'(0));
      check({tag, "_max"},    64'(a_out_row_max), 64'(emax));
      check({tag, "_norm0"},  a_out_norm, e0);
      check({tag, "_last0"},  64'(a_out_last), 64'(0));
      @(negedge clk);
      check({tag, "_norm1"},  a_out_norm, e1);
      check({tag, "_last1"},  64'(a_out_last), 64'(1));
      @(negedge clk);
      check({tag, "_inrdy1"}, 64'(a_in_ready), 64'(1));
      check({tag, "_done"},   64'(a_out_valid), 64'(0));
   endtask

   initial begin
      a_in_valid = 1'b0; a_in_scores = '0; a_out_ready = 1'b1;
      b_in_valid = 1'b0; b_in_scores = '0; b_out_ready = 1'b1;

      // Reset values
      repeat (2) @(negedge clk);
      check("rst_in_ready", 64'(a_in_ready), 64'(1));
      check("rst_out_valid", 64'(a_out_valid), 64'(0));
      check("rst_out_last", 64'(a_out_last), 64'(0));
      check("rst_out_norm", a_out_norm, 64'h0);
      check("rst_row_max", 64'(a_out_row_max), 64'(0));
      rst_n = 1'b1;
      @(negedge clk);

      // Mixed positive row
      send_row(64'h0010_0020_0005_0000, 64'h0030_0001_0002_0003);
      check_emit("pos", 64'hFFE0_FFF0_FFD5_FFD0, 64'h0000_FFD1_FFD2_FFD3, 16'h0030);

      // All-negative row; previous max 0x0030 must not leak in
      send_row(64'hFF00_FF00_FFF0_FF00, 64'hFF00_FF00_FF00_FF00);
      check_emit("neg", 64'hFF10_FF10_0000_FF10, 64'hFF10_FF10_FF10_FF10, 16'hFFF0);

      // Extreme range: 0x8000 - 0x7FFF
      send_row(64'h7FFF_0000_0000_0000, 64'h8000_0000_0000_0000);
`ifdef SOFTMAX_MAXSUB_SAT_EN
      check_emit("sat", 64'h0000_8001_8001_8001, 64'h8000_8001_8001_8001, 16'h7FFF);
`else
      check_emit("wrap", 64'h0000_8001_8001_8001, 64'h0001_8001_8001_8001, 16'h7FFF);
`endif

      // Backpressure for 5 cycles with in_valid asserted (must be ignored)
      a_out_ready = 1'b0;
      send_row(64'h0010_0020_0005_0000, 64'h0030_0001_0002_0003);
      for (int unsigned i = 0; i < 5; i++) begin
         check("bp_norm", a_out_norm, 64'hFFE0_FFF0_FFD5_FFD0);
         check("bp_in_ready", 64'(a_in_ready), 64'(0));
         check("bp_last", 64'(a_out_last), 64'(0));
         a_in_valid = 1'b1; a_in_scores = 64'h7777_7777_7777_7777;
         @(negedge clk);
      end
      a_in_valid = 1'b0; a_in_scores = '0; a_out_ready = 1'b1;
      check_emit("bp", 64'hFFE0_FFF0_FFD5_FFD0, 64'h0000_FFD1_FFD2_FFD3, 16'h0030);

      // Reset after one accepted beat discards the partial row
      a_in_valid = 1'b1; a_in_scores = 64'h7000_7000_7000_7000;
      @(negedge clk);
      a_in_valid = 1'b0; a_in_scores = '0;
      rst_n = 1'b0;
      @(negedge clk);
      check("mid_rst_in_ready", 64'(a_in_ready), 64'(1));
      check("mid_rst_out_valid", 64'(a_out_valid), 64'(0));
      check("mid_rst_out_norm", a_out_norm, 64'h0);
      check("mid_rst_row_max", 64'(a_out_row_max), 64'(0));
      rst_n = 1'b1;
      @(negedge clk);
      send_row(64'h0010_0020_0005_0000, 64'h0030_0001_0002_0003);
      check_emit("post_rst", 64'hFFE0_FFF0_FFD5_FFD0, 64'h0000_FFD1_FFD2_FFD3, 16'h0030);

      // ROW_BEATS = 1 with in_valid held high
      b_in_valid = 1'b1; b_in_scores = 64'h0100_0080_FFFF_0000;
      @(negedge clk);
      check("rb1_x_valid", 64'(b_out_valid), 64'(1));
      check("rb1_x_inrdy", 64'(b_in_ready), 64'(0));
      check("rb1_x_last", 64'(b_out_last), 64'(1));
      check("rb1_x_norm", b_out_norm, 64'h0000_FF80_FEFF_FF00);
      check("rb1_x_max", 64'(b_out_row_max), 64'(16'h0100));
      b_in_scores = 64'h8000_8001_8002_8003;
      @(negedge clk);
      check("rb1_gap_inrdy", 64'(b_in_ready), 64'(1));
      check("rb1_gap_valid", 64'(b_out_valid), 64'(0));
      @(negedge clk);
      b_in_valid = 1'b0;
      check("rb1_y_valid", 64'(b_out_valid), 64'(1));
      check("rb1_y_last", 64'(b_out_last), 64'(1));
      check("rb1_y_norm", b_out_norm, 64'hFFFD_FFFE_FFFF_0000);
      check("rb1_y_max", 64'(b_out_row_max), 64'(16'h8003));
      @(negedge clk);
      check("rb1_end_valid", 64'(b_out_valid), 64'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/softmax_max_sub.md
# softmax_max_sub

Row-max normalisation stage directly downstream of the 4-bit right-shift scaling stage in the self-attention head. It takes scaled Q·Kᵀ score vectors as input and buffers one full score row of ROW_BEATS beats. It computes the row maximum, then streams the row back out with the maximum subtracted from every element (x − max ≤ 0), so the following exp/softmax stage always sees non-positive, numerically stable inputs.

## Interface
- WIDTH_OUT, 16: signed element width, in and out
- FRAC_WIDTH_OUT, 8: fractional bits; carried through unchanged, no arithmetic effect
- CHUNK_SIZE, 4; NUM_CORES_A, 4; NUM_CORES_B, 1; TOTAL_MODULES, 2: lane geometry, as in the scaling stage
- TOTAL_INPUT_W, 2: number of lanes per beat
- ROW_BEATS, 4: beats per score row, ≥1
- Derived: ELEMS = CHUNK_SIZE·NUM_CORES_A·NUM_CORES_B·TOTAL_MODULES; LANE_BITS = WIDTH_OUT·ELEMS
- clk  in  1  single clock
- rst_n  in  1  reset, asynchronous, active-low
- in_scores  in  LANE_BITS [TOTAL_INPUT_W]  scaled scores; element e sits at bits [LANE_BITS−e·W−1 : LANE_BITS−(e+1)·W], element 0 at the MSB
- in_valid  in  1  beat present
- in_ready  out  1  beat accepted when in_valid && in_ready
- out_norm  out  LANE_BITS [TOTAL_INPUT_W]  x − row_max, same packing as input
- out_valid  out  1  output beat present
- out_ready  in  1  downstream accept
- out_last  out  1  marks the final beat of the row
- out_row_max  out  WIDTH_OUT  row maximum, stable while in EMIT

## Operation
- FSM with two states, COLLECT and EMIT. Reset state is COLLECT.
- COLLECT:
  - in_ready = 1.
  - Each accepted beat is written to buf[wr_idx], and wr_idx increments.
  - run_max updates to the signed max of run_max and all TOTAL_INPUT_W·ELEMS elements of the beat.
  - The first beat of a row loads the max unconditionally; it does not compare against a stale value.
  - On the beat where wr_idx = ROW_BEATS−1: row_max takes the final max, wr_idx returns to 0, and the state moves to EMIT.
- EMIT:
  - in_ready = 0; in_valid is ignored.
  - out_valid = 1.
  - out_norm = buf[rd_idx] − row_max, computed per element.
  - out_last = (rd_idx = ROW_BEATS−1).
  - On out_valid && out_ready, rd_idx increments. At the last beat, rd_idx returns to 0 and the state returns to COLLECT.
- Arithmetic:
  - Signed compare.
  - Subtraction is done at WIDTH_OUT+1 bits. The result lies in [−(2^W−1), 0] and is reduced to WIDTH_OUT per the Configuration section.
- Reset values: in_ready = 1; out_valid = 0; out_last = 0; out_norm = 0 (buf cleared); out_row_max = 0; all indices 0.
- Reset asserted mid-row or mid-emit discards the row. After release, the block is in COLLECT with wr_idx = 0.

## Timing
- in_ready and out_valid are decoded from registered state only, with no combinational in→out path.
- Last input beat accepted at edge t → out_valid = 1 from t onward, with the first output beat visible in cycle t+1.
- Throughput: 2·ROW_BEATS cycles per row when out_ready = 1 and no back-to-back overlap (single buffer).
- ROW_BEATS = 1: each accepted beat goes immediately to EMIT, and out_last = 1 on every output.
- out_ready low holds out_norm, out_last and rd_idx stable.
- A row is accepted only after the final output beat of the previous row has been taken: in_ready rises in the cycle after that handshake.
- The upstream scaling stage must honour in_ready; this block never drops an accepted beat.

## Configuration
- SOFTMAX_MAXSUB_SAT_EN defined: differences below −2^(W−1) saturate to −2^(W−1) (0x8000 at W = 16).
- SOFTMAX_MAXSUB_SAT_EN undefined: the low WIDTH_OUT bits are kept (wrap), saving area. Acceptable only when input range is guaranteed to be ≤ 2^(W−1).

## Structure
- Package softmax_pkg holds:
  - the state enum (COLLECT, EMIT);
  - ELEMS/LANE_BITS derivation functions;
  - a signed max function;
  - the saturating-subtract function.
- One sub-module, vec_max_reduce: combinational signed max tree over TOTAL_INPUT_W·ELEMS elements of a beat, producing one WIDTH_OUT result.
- buf is a register array [ROW_BEATS][TOTAL_INPUT_W] of LANE_BITS; no RAM inference required.

## Test plan
- Overrides for all tests: ELEMS = 4, TOTAL_INPUT_W = 1, ROW_BEATS = 2, W = 16.
- Row {0x0010, 0x0020, 0x0005, 0x0000}, {0x0030, 0x0001, 0x0002, 0x0003} → row_max = 0x0030; outputs {0xFFE0, 0xFFF0, 0xFFD5, 0xFFD0}, {0x0000, 0xFFD1, 0xFFD2, 0xFFD3}; out_last only on beat 2.
- All-negative row, every element 0xFF00 except one element of 0xFFF0 → row_max = 0xFFF0; that element outputs 0; all others output 0xFF10.
- Saturation: elements 0x7FFF and 0x8000 in the same row → with SOFTMAX_MAXSUB_SAT_EN, the 0x8000 element outputs 0x8000; without it, the output wraps to 0x0001.
- out_ready held low for 5 cycles during EMIT → out_norm stable, in_ready = 0, no beats lost; the next row starts only after the last handshake.
- rst_n pulsed low after 1 input beat → all outputs return to reset values; the next full row produces correct results unaffected by the stale beat.
- ROW_BEATS = 1, back-to-back in_valid → accept/emit alternate, out_last = 1 on every output beat.
